// File: rtl/add_sub_4bit_pkg.sv
// Shared constants for the 4-bit adder/subtractor slice.
package add_sub_4bit_pkg;

  // Operand and result width of the arithmetic datapath.
  localparam int unsigned ADD_SUB_WIDTH = 4;

endpackage : add_sub_4bit_pkg

// File: rtl/add_sub_4bit_full_adder.sv
// Single-bit full adder; the ripple stage of add_sub_4bit.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry-out of one bit position.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule : full_adder

// File: rtl/add_sub_4bit.sv
// Registered 4-bit ripple-carry adder/subtractor with scalar bit ports.
// c0 = 0 adds A + B; c0 = 1 subtracts as A + ~B + 1. In subtract mode the
// carry-out is an inverted borrow (1 means A >= B).
module add_sub_4bit
  import add_sub_4bit_pkg::*;
(
  output logic c4,
  output logic s3,
  output logic s2,
  output logic s1,
  output logic s0,
  input  logic b3,
  input  logic a3,
  input  logic b2,
  input  logic a2,
  input  logic b1,
  input  logic a1,
  input  logic b0,
  input  logic a0,
  input  logic c0,
  input  logic clk,
  input  logic rst_n
);

  logic [ADD_SUB_WIDTH-1:0] a_vec;
  logic [ADD_SUB_WIDTH-1:0] b_vec;
  logic [ADD_SUB_WIDTH-1:0] bx_vec;
  logic [ADD_SUB_WIDTH-1:0] sum_vec;
  logic [ADD_SUB_WIDTH:0]   carry;
  logic [ADD_SUB_WIDTH:0]   result_q;

  // Gather scalar pins into vectors and condition B for subtraction.
  always_comb begin
    a_vec    = {a3, a2, a1, a0};
    b_vec    = {b3, b2, b1, b0};
    bx_vec   = b_vec ^ {ADD_SUB_WIDTH{c0}};
    carry[0] = c0;
  end

  // Ripple chain: carry out of each stage feeds the next stage's carry-in.
  for (genvar i = 0; i < ADD_SUB_WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (a_vec[i]),
      .b    (bx_vec[i]),
      .cin  (carry[i]),
      .s    (sum_vec[i]),
      .cout (carry[i+1])
    );
  end

  // Output register: captures {carry-out, sum}; async clear drops any pending result.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, avoiding simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_q <= '0;
    else        result_q <= {carry[ADD_SUB_WIDTH], sum_vec};
  end

  // Drive the scalar output pins from the register.
  always_comb begin
    {c4, s3, s2, s1, s0} = result_q;
  end

endmodule : add_sub_4bit

// File: tb/tb_add_sub_4bit.sv
// Self-checking bench for add_sub_4bit: arithmetic reference model with a
// per-cycle compare process, literal directed cases, exhaustive sweep and random traffic.
module tb_add_sub_4bit;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic a3, a2, a1, a0, b3, b2, b1, b0, c0;
  logic c4, s3, s2, s1, s0;

  int tests  = 0;
  int failed = 0;
  bit cmp_en = 1'b0;
  logic [4:0] exp_q = '0;

  add_sub_4bit dut (
    .c4(c4), .s3(s3), .s2(s2), .s1(s1), .s0(s0),
    .b3(b3), .a3(a3), .b2(b2), .a2(a2), .b1(b1), .a1(a1),
    .b0(b0), .a0(a0), .c0(c0), .clk(clk), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned arithmetic on the operand values.
  function automatic logic [4:0] model(input int a, input int b, input bit sub);
    int r;
    if (!sub) begin
      r = a + b;
      return 5'(r);
    end
    r = a - b;
    return {(a >= b) ? 1'b1 : 1'b0, 4'(r & 15)};
  endfunction

  function automatic logic [4:0] dut_out();
    return {c4, s3, s2, s1, s0};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got c4=%b s=%b, expected c4=%b s=%b at %0t",
               name, got[4], got[3:0], exp[4], exp[3:0], $time);
    end
  endtask

  task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic c);
    {a3, a2, a1, a0} = a;
    {b3, b2, b1, b0} = b;
    c0 = c;
  endtask

  // Model register: one-edge latency, asynchronous clear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q = '0;
    else exp_q = model(int'({a3, a2, a1, a0}), int'({b3, b2, b1, b0}), c0);
  end

  // Compare process: outputs checked on every falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) check("cycle", dut_out(), exp_q);
  end

  // Drive inputs just after a rising edge, then check the literal result one edge later.
  task automatic lit(input string name, input logic [3:0] a, input logic [3:0] b,
                     input logic c, input logic [4:0] exp);
    @(posedge clk); #1;
    set_in(a, b, c);
    @(posedge clk);
    @(negedge clk);
    check(name, dut_out(), exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_in(4'd7, 4'd12, 1'b1);
    #1 rst_n = 1'b0;
    #2;
    check("reset_immediate", dut_out(), 5'b00000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_held", dut_out(), 5'b00000);
    cmp_en = 1'b1;
    #1 rst_n = 1'b1;

    lit("add_1_9",   4'd1,  4'd9,  1'b0, 5'b01010);
    lit("add_1_6",   4'd1,  4'd6,  1'b0, 5'b00111);
    lit("add_15_1",  4'd15, 4'd1,  1'b0, 5'b10000);
    lit("sub_9_1",   4'd9,  4'd1,  1'b1, 5'b11000);
    lit("sub_8_3",   4'd8,  4'd3,  1'b1, 5'b10101);
    lit("sub_15_15", 4'd15, 4'd15, 1'b1, 5'b10000);
    lit("sub_0_15",  4'd0,  4'd15, 1'b1, 5'b00001);
    lit("sub_0_1",   4'd0,  4'd1,  1'b1, 5'b01111);
    lit("add_4_1",   4'd4,  4'd1,  1'b0, 5'b00101);

    // Exhaustive sweep, a new combination every cycle.
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          @(posedge clk); #1;
          set_in(4'(a), 4'(b), c[0]);
        end

    // Random traffic with a reset pulse dropped between edges.
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      set_in(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
      if (n == 150) begin
        #1 rst_n = 1'b0;
        #1;
        check("reset_mid_op", dut_out(), 5'b00000);
        #1 rst_n = 1'b1;
      end
    end

    @(posedge clk); @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_add_sub_4bit

// File: doc/add_sub_4bit.md
# add_sub_4bit

Registered 4-bit ripple-carry adder/subtractor with bit-level scalar ports. A single mode bit `c0` selects the operation. When `c0`=0 the block computes A + B. When `c0`=1 it computes A − B as A + ~B + 1. The block is a leaf arithmetic element for datapath experiments and sits alongside the team's flip-flop primitives, with its result captured in output flops.

## Interface
- Parameters: none (width fixed at 4).
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a3`,`a2`,`a1`,`a0`  in  1 each  operand A, `a3` = MSB.
- `b3`,`b2`,`b1`,`b0`  in  1 each  operand B, `b3` = MSB.
- `c0`  in  1  mode / carry-in: 0 = add, 1 = subtract (A − B).
- `s3`,`s2`,`s1`,`s0`  out  1 each  registered result, `s3` = MSB.
- `c4`  out  1  registered carry-out of bit 3.
- Port order on instantiation: `c4, s3, s2, s1, s0, b3, a3, b2, a2, b1, a1, b0, a0, c0, clk, rst_n`.

## Operation
- Per bit i: bx_i = b_i XOR c0. Full adder: s_i = a_i ^ bx_i ^ k_i, k_{i+1} = a_i·bx_i + k_i·(a_i ^ bx_i), with k_0 = c0.
- Add mode (`c0`=0): {c4,s} = A + B, 5-bit unsigned result. `c4`=1 on unsigned overflow.
- Subtract mode (`c0`=1): s = (A − B) mod 16.
  - `c4`=1 means no borrow (A ≥ B).
  - `c4`=0 means borrow (A < B).
- No signed-overflow output. Callers derive signed overflow externally if needed.
- Inputs are not registered. The combinational sum is captured directly into the output flops.

## Timing
- Latency: 1 clock. Outputs reflect the inputs sampled at the previous rising edge of `clk`.
- Outputs are stable between edges. Glitches on the inputs never reach the outputs.
- `rst_n`=0 asynchronously forces `s3..s0`=0 and `c4`=0, regardless of `clk`.
- On release of `rst_n`, the first rising edge loads the current result.
- Reset asserted mid-operation discards the pending result. No partial state survives.
- A `c0` change takes effect on the next edge like any other input. There is no mode pipeline.
- Wrap-around:
  - 15+1 → s=0000, `c4`=1.
  - 0−1 → s=1111, `c4`=0.
  - 15−15 → s=0000, `c4`=1.

## Structure
- No shared package needed. If the codebase's package is in use, add only a constant for width 4.
- Sub-module `full_adder` (a, b, cin → s, cout), instantiated 4× in a ripple chain.
- XOR conditioning of B and the output register live in `add_sub_4bit`.
- The output register is 5 flops with asynchronous clear, built on the team's existing flip-flop primitive or as an equivalent always block.

## Test plan
- Reset: hold `rst_n`=0 with arbitrary inputs → s=0000, `c4`=0. Release, apply A=1, B=9, `c0`=0 → after one edge s=1010, `c4`=0.
- Add cases:
  - A=1, B=6, `c0`=0 → s=0111, `c4`=0.
  - A=15, B=1, `c0`=0 → s=0000, `c4`=1.
- Subtract without borrow:
  - A=9, B=1, `c0`=1 → s=1000, `c4`=1.
  - A=8, B=3, `c0`=1 → s=0101, `c4`=1.
  - A=15, B=15, `c0`=1 → s=0000, `c4`=1.
- Subtract with borrow:
  - A=0, B=15, `c0`=1 → s=0001, `c4`=0.
  - A=4, B=1, `c0`=0 → s=0101, `c4`=0 (sanity add).
- Latency/reset-mid-op:
  - Change inputs every cycle → each result appears exactly one edge later.
  - Assert `rst_n` between edges → outputs clear immediately.
- Exhaustive: all 512 combinations of A, B, `c0` → compare against the reference model {c4,s} = A + (B ^ {4{c0}}) + c0.
